// File: rtl/fdn_line_sequencer.sv
// Sequences the four delay lines of a feedback delay network through one
// shared single-port-style RAM: per sample period it reads the four delayed
// taps, waits for the feedback words, writes them back and advances the
// shared write pointer.
module fdn_line_sequencer #(
   parameter int DEF_D0 = 1152,
   parameter int DEF_D1 = 1399,
   parameter int DEF_D2 = 1617,
   parameter int DEF_D3 = 1873
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_stb,
   input  logic [63:0] fb_data,
   input  logic        fb_valid,
   input  logic [43:0] cfg_delay,
   input  logic        cfg_load,
   output logic        mem_re,
   output logic [12:0] mem_raddr,
   input  logic [15:0] mem_rdata,
   output logic        mem_we,
   output logic [12:0] mem_waddr,
   output logic [15:0] mem_wdata,
   output logic [63:0] tap_data,
   output logic        tap_valid,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_FB, WRITE} state_t;
   typedef logic [3:0][10:0] dly_t;

   localparam dly_t DLY_RST = {11'(DEF_D3), 11'(DEF_D2), 11'(DEF_D1), 11'(DEF_D0)};

   state_t            state, state_nx;
   logic [1:0]        k, k_nx;
   logic [10:0]       wp;
   logic [10:0]       rd_off;
   dly_t              d_q, pend_q;
   logic              pend_vld;
   logic [3:0][15:0]  fb_q;
   logic [3:0][15:0]  tap_q;
   logic              ret_idle;

   // A zero delay would read the word about to be written; clamp to one sample.
   function automatic logic [10:0] sat_delay(input logic [10:0] v);
      return (v == 11'd0) ? 11'd1 : v;
   endfunction

   // Unpack the configuration word into four clamped delays.
   function automatic dly_t unpack_cfg(input logic [43:0] c);
      dly_t r;
      for (int i = 0; i < 4; i++) r[i] = sat_delay(c[11*i +: 11]);
      return r;
   endfunction

   // Offset inside a line's region wraps modulo 2048 and never carries into k.
   assign rd_off   = wp - d_q[k];
   assign ret_idle = (state == WRITE) && (k == 2'd3);
   assign busy     = (state != IDLE);
   assign tap_data = tap_q;

   // Next-state logic and RAM port drive; ports are idle outside their state.
   always_comb begin
      state_nx  = state;
      k_nx      = k;
      mem_re    = 1'b0;
      mem_raddr = 13'd0;
      mem_we    = 1'b0;
      mem_waddr = 13'd0;
      mem_wdata = 16'd0;
      case (state)
         IDLE: begin
            if (sample_stb) begin
               state_nx = READ;
               k_nx     = 2'd0;
            end
         end
         READ: begin
            mem_re    = 1'b1;
            mem_raddr = {k, rd_off};
            k_nx      = k + 2'd1;
            if (k == 2'd3) state_nx = DRAIN;
         end
         DRAIN: state_nx = WAIT_FB;
         WAIT_FB: begin
            if (fb_valid) begin
               state_nx = WRITE;
               k_nx     = 2'd0;
            end
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_waddr = {k, wp};
            mem_wdata = fb_q[k];
            k_nx      = k + 2'd1;
            if (k == 2'd3) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register and line index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         k     <= 2'd0;
      end else begin
         state <= state_nx;
         k     <= k_nx;
      end
   end

   // Shared write pointer advances once per completed period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wp <= 11'd0;
      else if (ret_idle) wp <= wp + 11'd1;
   end

   // Read data lands one cycle after its read; slot 3 arrives during DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q     <= '0;
         tap_valid <= 1'b0;
      end else begin
         if (state == READ && k != 2'd0) tap_q[k - 2'd1] <= mem_rdata;
         if (state == DRAIN) tap_q[3] <= mem_rdata;
         tap_valid <= (state == DRAIN);
      end
   end

   // Feedback words are captured when accepted in WAIT_FB.
   always_ff @(posedge clk) begin
      if (state == WAIT_FB && fb_valid) fb_q <= fb_data;
   end

   // Sticky flag for strobes that arrive while a sequence is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overrun <= 1'b0;
      else if (sample_stb && state != IDLE) overrun <= 1'b1;
   end

   // Delay update: immediate in IDLE, otherwise deferred until the return to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q      <= DLY_RST;
         pend_q   <= DLY_RST;
         pend_vld <= 1'b0;
      end else if (cfg_load && (state == IDLE || ret_idle)) begin
         d_q      <= unpack_cfg(cfg_delay);
         pend_vld <= 1'b0;
      end else if (ret_idle && pend_vld) begin
         d_q      <= pend_q;
         pend_vld <= 1'b0;
      end else if (cfg_load) begin
         pend_q   <= unpack_cfg(cfg_delay);
         pend_vld <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fdn_line_sequencer.sv
// Directed bench for fdn_line_sequencer with a behavioural RAM attached.
module tb_fdn_line_sequencer;

   logic        clk;
   logic        rst_n;
   logic        sample_stb;
   logic [63:0] fb_data;
   logic        fb_valid;
   logic [43:0] cfg_delay;
   logic        cfg_load;
   logic        mem_re;
   logic [12:0] mem_raddr;
   logic [15:0] mem_rdata;
   logic        mem_we;
   logic [12:0] mem_waddr;
   logic [15:0] mem_wdata;
   logic [63:0] tap_data;
   logic        tap_valid;
   logic        busy;
   logic        overrun;

   int          total;
   int          bad;
   logic [10:0] wp_m;
   logic        ram_init;
   logic [15:0] ram [0:8191];

   fdn_line_sequencer dut (
      .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .fb_data(fb_data),
      .fb_valid(fb_valid), .cfg_delay(cfg_delay), .cfg_load(cfg_load),
      .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .tap_data(tap_data), .tap_valid(tap_valid), .busy(busy), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: one-cycle read latency, preloaded with addr ^ 16'hC000.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 8192; i++) ram[i] <= 16'(i) ^ 16'hC000;
      end else begin
         if (mem_we) ram[mem_waddr] <= mem_wdata;
         if (mem_re) mem_rdata <= ram[mem_raddr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tap(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (tap_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL tap_valid_timeout: got none want pulse within 20 cycles");
      end
   endtask

   task automatic wait_idle(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL idle_timeout: got busy want idle within 20 cycles");
      end
   endtask

   // One full period: strobe, catch first read address and taps, write w to all lines.
   task automatic run_period(input logic [15:0] w, output logic [63:0] tap,
                             output logic [12:0] a0, output logic ok);
      logic ok1, ok2;
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      a0 = mem_raddr;
      wait_tap(ok1);
      tap = tap_data;
      fb_valid = 1'b1;
      fb_data  = {4{w}};
      tick();
      fb_valid = 1'b0;
      wait_idle(ok2);
      ok = ok1 && ok2;
   endtask

   task automatic test_reset;
      total++;
      if ({mem_re, mem_we, mem_raddr, mem_waddr, mem_wdata, tap_data, tap_valid, busy, overrun} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got re=%b we=%b busy=%b ovr=%b tv=%b tap=%h want all 0",
                  mem_re, mem_we, busy, overrun, tap_valid, tap_data);
      end
   endtask

   task automatic test_basic_read;
      logic [12:0] exp_ra [4];
      exp_ra = '{13'h0380, 13'h0A89, 13'h11AF, 13'h18AF};
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem_re !== 1'b1 || mem_raddr !== exp_ra[i]) begin
            bad++;
            $display("FAIL read_addr%0d: got re=%b addr=%h want re=1 addr=%h", i, mem_re, mem_raddr, exp_ra[i]);
         end
         tick();
      end
      total++;
      if (mem_re !== 1'b0 || tap_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL drain_cycle: got re=%b tv=%b busy=%b want 0 0 1", mem_re, tap_valid, busy);
      end
      tick();
      total++;
      if (tap_valid !== 1'b1) begin
         bad++;
         $display("FAIL tap_valid_cycle6: got %b want 1", tap_valid);
      end
      total++;
      if (tap_data !== 64'hD8AF_D1AF_CA89_C380) begin
         bad++;
         $display("FAIL tap_data_basic: got %h want %h", tap_data, 64'hD8AF_D1AF_CA89_C380);
      end
   endtask

   task automatic test_write_advance;
      logic [12:0] exp_wa [4];
      logic [15:0] exp_wd [4];
      logic        ok;
      exp_wa = '{13'h0000, 13'h0800, 13'h1000, 13'h1800};
      exp_wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      fb_valid = 1'b1;
      fb_data  = 64'h4444_3333_2222_1111;
      tick();
      fb_valid = 1'b0;
      total++;
      if (tap_valid !== 1'b0) begin
         bad++;
         $display("FAIL tap_valid_width: got %b want 0", tap_valid);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_waddr !== exp_wa[i] || mem_wdata !== exp_wd[i]) begin
            bad++;
            $display("FAIL write%0d: got we=%b re=%b addr=%h data=%h want we=1 re=0 addr=%h data=%h",
                     i, mem_we, mem_re, mem_waddr, mem_wdata, exp_wa[i], exp_wd[i]);
         end
         tick();
      end
      total++;
      if (busy !== 1'b0 || mem_we !== 1'b0) begin
         bad++;
         $display("FAIL back_to_idle: got busy=%b we=%b want 0 0", busy, mem_we);
      end
      wait_idle(ok);
      wp_m = 11'd1;
   endtask

   task automatic test_delay;
      logic [63:0] tap;
      logic [12:0] a0;
      logic        ok;
      cfg_delay = {4{11'd3}};
      cfg_load  = 1'b1;
      tick();
      cfg_load  = 1'b0;
      for (int n = 0; n < 8; n++) begin
         run_period(16'(n), tap, a0, ok);
         if (n == 0) begin
            total++;
            if (a0 !== 13'h07FE) begin
               bad++;
               $display("FAIL delay3_addr_wp1: got %h want %h", a0, 13'h07FE);
            end
         end
         if (n >= 3) begin
            total++;
            if (tap !== {4{16'(n - 3)}}) begin
               bad++;
               $display("FAIL delay3_tap_n%0d: got %h want %h", n, tap, {4{16'(n - 3)}});
            end
         end
         wp_m = wp_m + 11'd1;
      end
   endtask

   task automatic test_zero_delay_wrap;
      logic [63:0] tap;
      logic [12:0] a0;
      logic        ok;
      logic [15:0] prev;
      logic [15:0] w;
      logic        was_zero;
      logic        seen_zero;
      int          errs;
      cfg_delay = 44'd0;
      cfg_load  = 1'b1;
      tick();
      cfg_load  = 1'b0;
      prev      = 16'd7;
      errs      = 0;
      seen_zero = 1'b0;
      for (int i = 0; i < 2100 && !seen_zero; i++) begin
         w        = 16'(i + 16'h0100);
         was_zero = (wp_m == 11'd0);
         run_period(w, tap, a0, ok);
         if (!ok) break;
         if (a0 !== {2'b00, 11'(wp_m - 11'd1)}) errs++;
         if (tap !== {4{prev}}) errs++;
         if (was_zero) begin
            seen_zero = 1'b1;
            total++;
            if (a0 !== 13'h07FF || tap !== {4{prev}}) begin
               bad++;
               $display("FAIL wrap_wp0: got addr=%h tap=%h want addr=%h tap=%h", a0, tap, 13'h07FF, {4{prev}});
            end
         end
         prev = w;
         wp_m = wp_m + 11'd1;
      end
      total++;
      if (errs != 0 || !seen_zero) begin
         bad++;
         $display("FAIL zero_delay_periods: got %0d bad periods wrap_seen=%b want 0 and 1", errs, seen_zero);
      end
   endtask

   task automatic test_overrun;
      logic ok;
      int   reads;
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL overrun_initial: got %b want 0", overrun);
      end
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      wait_tap(ok);
      tick();
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set: got %b want 1", overrun);
      end
      reads = 0;
      for (int i = 0; i < 5; i++) begin
         if (mem_re === 1'b1) reads++;
         tick();
      end
      total++;
      if (reads != 0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL overrun_no_reads: got reads=%0d busy=%b want 0 1", reads, busy);
      end
      fb_valid = 1'b1;
      fb_data  = {4{16'hBEEF}};
      tick();
      fb_valid = 1'b0;
      wait_idle(ok);
      wp_m = wp_m + 11'd1;
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_sticky: got %b want 1", overrun);
      end
   endtask

   task automatic test_cfg_defer;
      logic [63:0] tap;
      logic [12:0] a0;
      logic        ok;
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      a0        = mem_raddr;
      cfg_delay = {4{11'd5}};
      cfg_load  = 1'b1;
      tick();
      cfg_load  = 1'b0;
      total++;
      if (a0 !== {2'b00, 11'(wp_m - 11'd1)} || mem_raddr !== {2'b01, 11'(wp_m - 11'd1)}) begin
         bad++;
         $display("FAIL cfg_defer_same_period: got a0=%h a1=%h want %h %h",
                  a0, mem_raddr, {2'b00, 11'(wp_m - 11'd1)}, {2'b01, 11'(wp_m - 11'd1)});
      end
      wait_tap(ok);
      fb_valid = 1'b1;
      fb_data  = {4{16'h0055}};
      tick();
      fb_valid = 1'b0;
      wait_idle(ok);
      wp_m = wp_m + 11'd1;
      run_period(16'h0066, tap, a0, ok);
      total++;
      if (a0 !== {2'b00, 11'(wp_m - 11'd5)}) begin
         bad++;
         $display("FAIL cfg_defer_next_period: got %h want %h", a0, {2'b00, 11'(wp_m - 11'd5)});
      end
      wp_m = wp_m + 11'd1;
   endtask

   task automatic test_reset_mid_write;
      logic ok;
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      wait_tap(ok);
      fb_valid = 1'b1;
      fb_data  = {4{16'h7777}};
      tick();
      fb_valid = 1'b0;
      tick();
      tick();
      total++;
      if (mem_we !== 1'b1 || mem_waddr !== {2'd2, wp_m}) begin
         bad++;
         $display("FAIL write_k2_before_reset: got we=%b addr=%h want 1 %h", mem_we, mem_waddr, {2'd2, wp_m});
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (mem_we !== 1'b0 || mem_re !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || tap_data !== 64'd0) begin
         bad++;
         $display("FAIL async_reset: got we=%b re=%b busy=%b ovr=%b tap=%h want all 0",
                  mem_we, mem_re, busy, overrun, tap_data);
      end
      tick();
      rst_n = 1'b1;
      tick();
      wp_m = 11'd0;
      sample_stb = 1'b1;
      tick();
      sample_stb = 1'b0;
      total++;
      if (mem_raddr !== 13'h0380) begin
         bad++;
         $display("FAIL post_reset_addr0: got %h want %h", mem_raddr, 13'h0380);
      end
      tick();
      total++;
      if (mem_raddr !== 13'h0A89) begin
         bad++;
         $display("FAIL post_reset_addr1: got %h want %h", mem_raddr, 13'h0A89);
      end
      wait_tap(ok);
      fb_valid = 1'b1;
      fb_data  = 64'd0;
      tick();
      fb_valid = 1'b0;
      wait_idle(ok);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      wp_m       = 11'd0;
      rst_n      = 1'b0;
      ram_init   = 1'b1;
      sample_stb = 1'b0;
      fb_data    = 64'd0;
      fb_valid   = 1'b0;
      cfg_delay  = 44'd0;
      cfg_load   = 1'b0;
      tick();
      ram_init = 1'b0;
      tick();
      test_reset();
      rst_n = 1'b1;
      tick();
      test_basic_read();
      test_write_advance();
      test_delay();
      test_zero_delay_wrap();
      test_overrun();
      test_cfg_defer();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
